cla_sub_seq: RTL and testbench



---
 rtl/cla_pkg.sv | 18 +
 rtl/cla_slice.sv | 33 +++
 rtl/cla_sub_seq.sv | 118 +++++++++++
 tb/tb_cla_sub_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared constants for the iterative carry-lookahead subtractor: state encoding,
// default operand/slice widths and the slice-count derivation.
package cla_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational CHUNK-bit carry-lookahead adder slice; zero latency, no flow control.
module cla_slice
  import cla_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK-1:0] g;
  logic [CHUNK-1:0] p;
  logic [CHUNK:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Generate/propagate recurrence; synthesis flattens this into lookahead terms.
  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign sum  = p ^ c[CHUNK-1:0];
  assign cout = c[CHUNK];

endmodule

// File: rtl/cla_sub_seq.sv
// Iterative A-B, one CHUNK slice per cycle: out_valid NCHUNK cycles after acceptance, result
// held in DONE until out_ready; no overlap. Optional ovf output under CLA_SUB_OVF_EN.
module cla_sub_seq
  import cla_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             borrow,
  output logic             busy
`ifdef CLA_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IDXW-1:0]  idx_q;
  logic             carry_q;

  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK-1:0] d_sl;
  logic             c_out;
  logic             accept;
  logic             last;

  assign a_sl   = a_q[int'(idx_q)*CHUNK +: CHUNK];
  assign b_sl   = b_q[int'(idx_q)*CHUNK +: CHUNK];
  assign accept = in_valid && in_ready;
  assign last   = (idx_q == LAST_IDX);

  // Subtraction as a + ~b + 1: the initial carry of 1 supplies the two's-complement increment.
  cla_slice #(.CHUNK(CHUNK)) u_slice (
    .a    (a_sl),
    .b    (~b_sl),
    .cin  (carry_q),
    .sum  (d_sl),
    .cout (c_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)    state_d = ST_CALC;
      ST_CALC: if (last)      state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q == ST_CALC) || (state_q == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b1;
      Diff    <= '0;
      borrow  <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      if (accept) begin
        a_q     <= A;
        b_q     <= B;
        idx_q   <= '0;
        carry_q <= 1'b1;
      end
    end else if (state_q == ST_CALC) begin
      Diff[int'(idx_q)*CHUNK +: CHUNK] <= d_sl;
      carry_q <= c_out;
      idx_q   <= idx_q + IDXW'(1);
      if (last) begin
        borrow <= ~c_out;
      end
    end
  end

`ifdef CLA_SUB_OVF_EN
  // The top slice's MSB is Diff[MSB], so overflow is resolved on the same edge as borrow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if ((state_q == ST_CALC) && last) begin
      ovf <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_sl[CHUNK-1] != a_q[WIDTH-1]);
    end
  end
`endif

endmodule

// File: tb/tb_cla_sub_seq.sv
// Randomized and directed bench for cla_sub_seq against an arithmetic reference model.
module tb_cla_sub_seq;

  localparam int WIDTH  = 32;
  localparam int NCHUNK = 4;
  localparam int LAT_BOUND = 20;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Diff;
  logic             borrow;
  logic             busy;
`ifdef CLA_SUB_OVF_EN
  logic             ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  cla_sub_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Diff      (Diff),
    .borrow    (borrow),
    .busy      (busy)
`ifdef CLA_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain modular / unsigned / signed arithmetic.
  function automatic logic [WIDTH-1:0] ref_diff(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return a - b;
  endfunction

  function automatic logic ref_borrow(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (a < b);
  endfunction

  function automatic logic ref_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    longint d;
    d = longint'($signed(a)) - longint'($signed(b));
    return (d > 64'sd2147483647) || (d < -64'sd2147483648);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    check_eq({tag, "_diff"}, 64'(Diff), 64'(ref_diff(a, b)));
    check_eq({tag, "_borrow"}, 64'(borrow), 64'(ref_borrow(a, b)));
`ifdef CLA_SUB_OVF_EN
    check_eq({tag, "_ovf"}, 64'(ovf), 64'(ref_ovf(a, b)));
`endif
  endtask

  // One full transaction; hold = cycles of out_ready=0 back-pressure while in DONE.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int hold);
    int k;
    bit saw_ready;
    check_eq({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
    A         = a;
    B         = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid  = 1'b0;
    A         = $urandom;
    B         = $urandom;
    k         = 0;
    saw_ready = 1'b0;
    while (!out_valid && k < LAT_BOUND) begin
      if (in_ready) saw_ready = 1'b1;
      check_eq({tag, "_busy_calc"}, 64'(busy), 64'd1);
      step();
      k++;
    end
    check_eq({tag, "_latency"}, 64'(k), 64'(NCHUNK));
    check_eq({tag, "_in_ready_calc"}, 64'(saw_ready), 64'd0);
    check_result(tag, a, b);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      A        = $urandom;
      step();
      check_eq({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      check_eq({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
      check_result({tag, "_hold"}, a, b);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq({tag, "_release_valid"}, 64'(out_valid), 64'd0);
    check_eq({tag, "_release_in_ready"}, 64'(in_ready), 64'd1);
    check_eq({tag, "_release_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_diff", 64'(Diff), 64'd0);
    check_eq("rst_borrow", 64'(borrow), 64'd0);
`ifdef CLA_SUB_OVF_EN
    check_eq("rst_ovf", 64'(ovf), 64'd0);
`endif
    step();
    step();
    rst_n = 1'b1;
    step();

    run_op("basic", 32'd5, 32'd3, 0);
    run_op("under", 32'd3, 32'd5, 0);
    run_op("equal", 32'h12345678, 32'h12345678, 0);
    run_op("xslice", 32'h01000000, 32'd1, 0);
    run_op("bp", 32'hDEADBEEF, 32'h0000FFFF, 10);
    run_op("ovf_pos", 32'h80000000, 32'd1, 0);
    run_op("ovf_neg", 32'h7FFFFFFF, 32'hFFFFFFFF, 1);

    // Abort two cycles into CALC.
    A        = 32'hFFFF0000;
    B        = 32'h00001234;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check_eq("abort_out_valid", 64'(out_valid), 64'd0);
    check_eq("abort_diff", 64'(Diff), 64'd0);
    check_eq("abort_in_ready", 64'(in_ready), 64'd1);
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_borrow", 64'(borrow), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    run_op("after_rst", 32'd10, 32'd4, 0);

    for (int n = 0; n < 30; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra + 32'($urandom_range(1, 3));
        default: rb = $urandom;
      endcase
      run_op("rand", ra, rb, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
